// File: rtl/instruction_pair_queue.sv
// instruction_pair_queue
//   In-order instruction prefetch queue. Fetches 16-bit words from
//   instruction memory with at most one request outstanding, and presents the
//   head entry and the head+1 entry together so a fusable pair is visible in
//   one cycle. Up to two entries retire per cycle unless stalled. A redirect
//   flushes the queue and restarts fetching at redirect_pc.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   imem_req / imem_addr     fetch request and its address
//   imem_ready               request accepted when imem_req && imem_ready
//   imem_rvalid / imem_rdata in-order fetch response
//   redirect / redirect_pc   flush queue, restart fetch and head at redirect_pc
//   stall                    blocks all pops this cycle
//   consume                  entries retired this cycle (3 behaves as 2)
//   instruction(_valid)      head entry, 0 when not valid
//   next_instruction(_valid) head+1 entry, 0 when not valid
//   head_pc                  address of the head entry
//   occupancy                entries currently held
//   flush_count              redirects seen, saturating
//   fsm_state                fetch FSM state (0 IDLE, 1 WAIT, 2 DROP) for observation
//
// Handshake: the fetch request follows valid/ready. A transfer happens in a
// cycle where imem_req && imem_ready. Once imem_req rises, imem_req and
// imem_addr stay stable until the transfer; only redirect (or rst) withdraws
// a request. Responses carry no ready: exactly one imem_rvalid returns per
// accepted request, in order.

module instruction_pair_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [15:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       stall,
    input  logic [1:0]                 consume,
    output logic [15:0]                instruction,
    output logic [15:0]                next_instruction,
    output logic                       instruction_valid,
    output logic                       next_instruction_valid,
    output logic [ADDR_W-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                flush_count,
    output logic [1:0]                 fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state_q, state_next;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [ADDR_W-1:0]  fetch_pc_q, head_pc_q;
    logic [15:0]        flush_q;
    logic [15:0]        mem [DEPTH];

    logic [1:0]         consume_clamped;
    logic [1:0]         pops;
    logic               accept;
    logic               push;
    logic [PTR_W-1:0]   rd_ptr_plus1;

    // Pop count: never more than the entries actually held.
    always_comb begin
        consume_clamped = (consume == 2'd3) ? 2'd2 : consume;
        pops            = 2'd0;
        if (!stall) begin
            if (count_q >= CNT_W'(2))
                pops = consume_clamped;
            else if (count_q == CNT_W'(1))
                pops = (consume_clamped != 2'd0) ? 2'd1 : 2'd0;
        end
    end

    // A request is only raised in IDLE with a free slot, so the response of
    // every accepted request is guaranteed somewhere to land. Count cannot
    // rise while IDLE, so a raised request stays raised until accepted.
    always_comb begin
        imem_req  = !rst && (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect;
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_ready;
        push      = (state_q == S_WAIT) && imem_rvalid && !redirect;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:  if (accept)      state_next = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_next = S_IDLE;
            S_DROP:  if (imem_rvalid) state_next = S_IDLE;
            default:                  state_next = S_IDLE;
        endcase
        // A response landing in the redirect cycle is thrown away here; a
        // response still in flight afterwards is swallowed by DROP.
        if (redirect) begin
            if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid)
                state_next = S_DROP;
            else
                state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= '0;
            head_pc_q  <= '0;
            flush_q    <= '0;
        end else begin
            state_q <= state_next;
            if (redirect) begin
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= redirect_pc;
                head_pc_q  <= redirect_pc;
                if (flush_q != 16'hFFFF)
                    flush_q <= flush_q + 16'd1;
            end else begin
                count_q   <= count_q + CNT_W'(push) - CNT_W'(pops);
                rd_ptr_q  <= rd_ptr_q + PTR_W'(pops);
                head_pc_q <= head_pc_q + ADDR_W'(pops);
                if (push)
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (accept)
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end
        end
    end

    // Storage needs no reset: the read side is gated by count.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr_q] <= imem_rdata;
    end

    always_comb begin
        rd_ptr_plus1           = rd_ptr_q + PTR_W'(1);
        instruction_valid      = (count_q >= CNT_W'(1));
        next_instruction_valid = (count_q >= CNT_W'(2));
        instruction            = instruction_valid ? mem[rd_ptr_q] : 16'h0000;
        next_instruction       = next_instruction_valid ? mem[rd_ptr_plus1] : 16'h0000;
        head_pc                = head_pc_q;
        occupancy              = count_q;
        flush_count            = flush_q;
        fsm_state              = state_q;
    end

endmodule

// File: tb/tb_instruction_pair_queue.sv
module tb_instruction_pair_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [15:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic [1:0]        consume;
  logic [15:0]       instruction;
  logic [15:0]       next_instruction;
  logic              instruction_valid;
  logic              next_instruction_valid;
  logic [ADDR_W-1:0] head_pc;
  logic [2:0]        occupancy;
  logic [15:0]       flush_count;
  logic [1:0]        fsm_state;

  always #5 clk = ~clk;

  instruction_pair_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .consume(consume),
    .instruction(instruction), .next_instruction(next_instruction),
    .instruction_valid(instruction_valid), .next_instruction_valid(next_instruction_valid),
    .head_pc(head_pc), .occupancy(occupancy), .flush_count(flush_count),
    .fsm_state(fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents, head address, fetch address, flushes,
  // and whether a fetch is in flight (and whether its answer is unwanted).
  logic [15:0]       exp_q[$];
  logic [ADDR_W-1:0] m_head, m_fetch;
  logic [15:0]       m_flush;
  bit                m_out, m_stale;

  // Memory responder: one pending answer, returned after a random delay.
  bit                pend;
  logic [ADDR_W-1:0] pend_addr;
  int                pend_delay;
  int                dly_min = 0, dly_max = 0;

  // One clock cycle: respond, check request side, advance model, check read side.
  task automatic tick();
    bit   exp_req, acc;
    int   c, pops;
    logic [15:0] e_ins, e_nxt;
    if (pend && pend_delay == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h1000 + 16'(pend_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    #1;
    exp_req = !rst && !m_out && (exp_q.size() < DEPTH) && !redirect;
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req at %0t: got %b want %b", $time, imem_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== m_fetch) begin
        errors++;
        $display("FAIL imem_addr at %0t: got %h want %h", $time, imem_addr, m_fetch);
      end
    end
    acc = exp_req && imem_ready;
    if (imem_rvalid) pend = 1'b0;
    else if (pend) pend_delay--;
    if (acc) begin
      pend       = 1'b1;
      pend_addr  = m_fetch;
      pend_delay = $urandom_range(dly_max, dly_min);
    end
    if (rst) begin
      exp_q.delete();
      m_head = '0; m_fetch = '0; m_flush = '0; m_out = 0; m_stale = 0;
    end else if (redirect) begin
      exp_q.delete();
      m_head  = redirect_pc;
      m_fetch = redirect_pc;
      if (m_flush != 16'hFFFF) m_flush++;
      if (imem_rvalid) m_out = 0;
      m_stale = m_out;
    end else begin
      c    = (consume == 2'd3) ? 2 : int'(consume);
      pops = stall ? 0 : ((c < exp_q.size()) ? c : exp_q.size());
      repeat (pops) void'(exp_q.pop_front());
      m_head = m_head + ADDR_W'(pops);
      if (imem_rvalid && m_out) begin
        if (!m_stale) exp_q.push_back(imem_rdata);
        m_out = 0; m_stale = 0;
      end
      if (acc) begin
        m_out   = 1;
        m_fetch = m_fetch + ADDR_W'(1);
      end
    end
    @(posedge clk);
    #1;
    e_ins = (exp_q.size() >= 1) ? exp_q[0] : 16'h0000;
    e_nxt = (exp_q.size() >= 2) ? exp_q[1] : 16'h0000;
    checks++;
    if (occupancy !== 3'(exp_q.size())) begin
      errors++;
      $display("FAIL occupancy at %0t: got %0d want %0d", $time, occupancy, exp_q.size());
    end
    checks++;
    if (instruction !== e_ins || instruction_valid !== (exp_q.size() >= 1)) begin
      errors++;
      $display("FAIL head at %0t: got %h/%b want %h/%b", $time, instruction, instruction_valid, e_ins, exp_q.size() >= 1);
    end
    checks++;
    if (next_instruction !== e_nxt || next_instruction_valid !== (exp_q.size() >= 2)) begin
      errors++;
      $display("FAIL next at %0t: got %h/%b want %h/%b", $time, next_instruction, next_instruction_valid, e_nxt, exp_q.size() >= 2);
    end
    checks++;
    if (head_pc !== m_head) begin
      errors++;
      $display("FAIL head_pc at %0t: got %h want %h", $time, head_pc, m_head);
    end
    checks++;
    if (flush_count !== m_flush) begin
      errors++;
      $display("FAIL flush_count at %0t: got %0d want %0d", $time, flush_count, m_flush);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00 || occupancy !== 3'd0 || flush_count !== 16'h0 || head_pc !== 8'h00 || instruction !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h occ=%0d flush=%0d head=%h ins=%h want all 0",
               imem_req, imem_addr, occupancy, flush_count, head_pc, instruction);
    end
    rst = 1'b0;
  endtask

  task automatic wait_size(input int n, input string name);
    int i;
    for (i = 0; i < 60 && exp_q.size() < n; i++) tick();
    if (exp_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d entries want %0d", name, exp_q.size(), n);
    end
  endtask

  task automatic test_fill();
    imem_ready = 1'b1; dly_min = 0; dly_max = 0; consume = 2'd0;
    wait_size(4, "fill");
    tick();
    checks++;
    if (occupancy !== 3'd4 || instruction !== 16'h1000 || next_instruction !== 16'h1001 ||
        !instruction_valid || !next_instruction_valid || imem_req !== 1'b0 || imem_addr !== 8'h04) begin
      errors++;
      $display("FAIL fill: got occ=%0d ins=%h nxt=%h req=%b addr=%h want 4 1000 1001 0 04",
               occupancy, instruction, next_instruction, imem_req, imem_addr);
    end
  endtask

  task automatic test_pop_pair();
    consume = 2'd2;
    tick();
    consume = 2'd0;
    checks++;
    if (instruction !== 16'h1002 || next_instruction !== 16'h1003 || head_pc !== 8'h02) begin
      errors++;
      $display("FAIL pop_pair: got ins=%h nxt=%h head=%h want 1002 1003 02", instruction, next_instruction, head_pc);
    end
    wait_size(4, "refill");
  endtask

  task automatic test_stall();
    stall = 1'b1; consume = 2'd2;
    repeat (5) tick();
    stall = 1'b0; consume = 2'd0;
    checks++;
    if (occupancy !== 3'd4 || instruction !== 16'h1002 || next_instruction !== 16'h1003 || head_pc !== 8'h02) begin
      errors++;
      $display("FAIL stall: got occ=%0d ins=%h nxt=%h head=%h want 4 1002 1003 02", occupancy, instruction, next_instruction, head_pc);
    end
  endtask

  task automatic test_over_consume();
    imem_ready = 1'b0; consume = 2'd1;
    repeat (3) tick();
    consume = 2'd2;
    tick();
    consume = 2'd0;
    checks++;
    if (occupancy !== 3'd0 || instruction_valid !== 1'b0 || next_instruction_valid !== 1'b0 ||
        instruction !== 16'h0 || next_instruction !== 16'h0 || head_pc !== 8'h06) begin
      errors++;
      $display("FAIL over_consume: got occ=%0d v=%b%b ins=%h nxt=%h head=%h want 0 00 0000 0000 06",
               occupancy, instruction_valid, next_instruction_valid, instruction, next_instruction, head_pc);
    end
  endtask

  task automatic test_redirect_wait();
    int i;
    dly_min = 1; dly_max = 1; imem_ready = 1'b1;
    for (i = 0; i < 10 && !m_out; i++) tick();
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    checks++;
    if (occupancy !== 3'd0 || flush_count !== 16'd1) begin
      errors++;
      $display("FAIL redirect_wait: got occ=%0d flush=%0d want 0 1", occupancy, flush_count);
    end
    dly_min = 0; dly_max = 0;
    wait_size(1, "redirect");
    checks++;
    if (instruction !== 16'h1040) begin
      errors++;
      $display("FAIL redirect_first: got %h want 1040", instruction);
    end
  endtask

  task automatic test_push_pop_same();
    int i;
    logic [15:0] want;
    dly_min = 0; dly_max = 0; imem_ready = 1'b1; consume = 2'd0;
    for (i = 0; i < 40 && !(exp_q.size() == 3 && pend && pend_delay == 0); i++) tick();
    if (!(exp_q.size() == 3 && pend && pend_delay == 0)) begin
      checks++; errors++;
      $display("FAIL push_pop_setup: got %0d entries want 3 with response due", exp_q.size());
    end
    want = exp_q[1];
    consume = 2'd1;
    tick();
    consume = 2'd0;
    checks++;
    if (occupancy !== 3'd3 || instruction !== want) begin
      errors++;
      $display("FAIL push_pop_same: got occ=%0d ins=%h want 3 %h", occupancy, instruction, want);
    end
  endtask

  task automatic test_wrap();
    imem_ready = 1'b1; consume = 2'd0;
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    wait_size(3, "wrap");
    imem_ready = 1'b0;
    checks++;
    if (instruction !== 16'h10FE || next_instruction !== 16'h10FF) begin
      errors++;
      $display("FAIL wrap_fetch: got %h %h want 10FE 10FF", instruction, next_instruction);
    end
    consume = 2'd2;
    tick();
    consume = 2'd0;
    checks++;
    if (head_pc !== 8'h00 || instruction !== 16'h1000 || flush_count !== 16'd2) begin
      errors++;
      $display("FAIL wrap_head: got head=%h ins=%h flush=%0d want 00 1000 2", head_pc, instruction, flush_count);
    end
  endtask

  task automatic test_random();
    dly_min = 0; dly_max = 3;
    repeat (400) begin
      stall       = ($urandom_range(3, 0) == 0);
      consume     = 2'($urandom_range(3, 0));
      imem_ready  = ($urandom_range(2, 0) != 0);
      redirect    = ($urandom_range(29, 0) == 0);
      redirect_pc = 8'($urandom);
      tick();
    end
    redirect = 1'b0; stall = 1'b0; consume = 2'd0;
  endtask

  task automatic test_mid_reset();
    imem_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (occupancy !== 3'd0 || flush_count !== 16'd0 || head_pc !== 8'h00 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got occ=%0d flush=%0d head=%h req=%b want 0 0 00 0", occupancy, flush_count, head_pc, imem_req);
    end
    rst = 1'b0;
    dly_min = 0; dly_max = 0;
    wait_size(1, "after_reset");
    checks++;
    if (instruction !== 16'h1000) begin
      errors++;
      $display("FAIL after_reset_first: got %h want 1000", instruction);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0; consume = 2'd0;
    exp_q.delete();
    m_head = '0; m_fetch = '0; m_flush = '0; m_out = 0; m_stale = 0;
    pend = 0; pend_addr = '0; pend_delay = 0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_pop_pair();
    test_stall();
    test_over_consume();
    test_redirect_wait();
    test_push_pop_same();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
